// File: rtl/dac_spi_rx.sv
// dac_spi_rx: oversampling SPI (mode 0) receiver for the 16-bit DAC command
// frame. Frame = {ctrl[3:0], code[9:0], 2'bxx}, shifted in MSB first.
// Ports: clk, rst (async, active high); sclk, mosi, cs (async pins);
//        dac_code, ctrl (registered results), frame_valid, frame_err (1-clk
//        pulses), busy (high while a frame is being shifted).
module dac_spi_rx #(
  parameter logic [3:0]  CTRL_WRITE = 4'b0001,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic [9:0] dac_code,
  output logic [3:0] ctrl,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    ARMWAIT,
    IDLE,
    SHIFT
  } state_t;

  localparam logic [4:0] FB = 5'(FRAME_BITS);

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q, mosi_q;
  logic sclk_rise_q, cs_rise_q, cs_fall_q;

  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  arm_q, arm_d;
  logic [9:0]  dac_q, dac_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Synchronisers plus registered edge pulses. mosi gets the same depth
  // as the sclk edge pulse so the sampled bit lines up with its edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_s3_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      mosi_q      <= 1'b0;
      sclk_rise_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      cs_s1_q     <= cs;
      cs_s2_q     <= cs_s1_q;
      cs_s3_q     <= cs_s2_q;
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      mosi_q      <= mosi_s2_q;
      sclk_rise_q <= sclk_s2_q & ~sclk_s3_q;
      cs_rise_q   <= cs_s2_q & ~cs_s3_q;
      cs_fall_q   <= ~cs_s2_q & cs_s3_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARMWAIT;
      shreg_q <= '0;
      cnt_q   <= '0;
      arm_q   <= '0;
      dac_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      dac_q   <= dac_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dac_d   = dac_q;
    ctrl_d  = ctrl_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    unique case (state_q)
      // The cs chain resets high, so its reset value says nothing about
      // the pin. arm_q waits until the chain has really sampled cs.
      ARMWAIT: begin
        if (arm_q == 2'd3 && cs_s3_q) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall_q) begin
          state_d = SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // cs rise has priority over a coincident sclk rise.
        if (cs_rise_q) begin
          state_d = IDLE;
          if (cnt_q != FB) begin
            err_d = 1'b1;
          end else if (shreg_q[15:12] == CTRL_WRITE) begin
            valid_d = 1'b1;
            dac_d   = shreg_q[11:2];
            ctrl_d  = shreg_q[15:12];
          end else begin
            err_d  = 1'b1;
            ctrl_d = shreg_q[15:12];
          end
        end else if (sclk_rise_q && !cs_s3_q) begin
          shreg_d = {shreg_q[14:0], mosi_q};
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ARMWAIT;
    endcase
  end

  assign dac_code    = dac_q;
  assign ctrl        = ctrl_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb_dac_spi_rx: table vectors, hand sequences and random frames for
// dac_spi_rx, checked by a frame-level model and a pulse scoreboard.
module tb_dac_spi_rx;

  logic       clk = 1'b0;
  logic       rst, sclk, mosi, cs;
  logic [9:0] dac_code;
  logic [3:0] ctrl;
  logic       frame_valid, frame_err, busy;

  always #5 clk = ~clk;

  dac_spi_rx dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs),
    .dac_code(dac_code), .ctrl(ctrl), .frame_valid(frame_valid),
    .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    int         kind;
    logic [9:0] code;
    logic [3:0] ctl;
    int         rcyc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic [1:0]  kind;
    logic [9:0]  code;
    logic [3:0]  ctl;
  } vec_t;

  exp_t       q[$];
  exp_t       mon_e;
  exp_t       none;
  vec_t       tbl[9];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [9:0] m_code = '0;
  logic [3:0] m_ctrl = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: what the receiver should report for a frame.
  task automatic model(input logic [31:0] data, input int nbits);
    exp_t       e;
    logic [15:0] f;
    f = data[15:0];
    e.rcyc = cyc;
    if (nbits != 16) begin
      e.kind = 2;
    end else begin
      m_ctrl = f[15:12];
      if (f[15:12] == 4'h1) begin
        e.kind = 1;
        m_code = f[11:2];
      end else begin
        e.kind = 2;
      end
    end
    e.code = m_code;
    e.ctl  = m_ctrl;
    q.push_back(e);
  endtask

  // mode 0: no pulse expected, 1: model, 2: use te
  task automatic send(input logic [31:0] data, input int nbits,
                      input int half, input int gap, input int mode,
                      input exp_t te);
    exp_t e;
    cs = 1'b0;
    tick(half);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      tick(half);
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
    tick(4);
    if (mode != 0) chk("busy_high", 32'(busy), 32'd1);
    cs = 1'b1;
    if (mode == 1) begin
      model(data, nbits);
    end else if (mode == 2) begin
      e = te;
      e.rcyc = cyc;
      q.push_back(e);
    end
    tick(gap);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick(1);
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_dac", 32'(dac_code), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  // Scoreboard: every pulse must match the oldest expected frame.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst && (frame_valid || frame_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse valid %0b err %0b",
                 frame_valid, frame_err);
      end else begin
        mon_e = q.pop_front();
        chk("kind", {30'b0, frame_err, frame_valid},
            (mon_e.kind == 1) ? 32'd1 : 32'd2);
        chk("dac_code", 32'(dac_code), 32'(mon_e.code));
        chk("ctrl", 32'(ctrl), 32'(mon_e.ctl));
        chk("latency", 32'(cyc - mon_e.rcyc), 32'd4);
        chk("busy_low", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #990000;
    $display("FAIL timeout checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int          nb;
    exp_t        te;
    none = '{0, 10'h0, 4'h0, 0};
    tbl[0] = '{32'h1FFC, 16, 2'd1, 10'h3FF, 4'h1};
    tbl[1] = '{32'h1554, 16, 2'd1, 10'h155, 4'h1};
    tbl[2] = '{32'h1234, 15, 2'd2, 10'h155, 4'h1};
    tbl[3] = '{32'h1554, 16, 2'd1, 10'h155, 4'h1};
    tbl[4] = '{32'h0ABCD, 17, 2'd2, 10'h155, 4'h1};
    tbl[5] = '{32'h1554, 16, 2'd1, 10'h155, 4'h1};
    tbl[6] = '{32'h0, 0, 2'd2, 10'h155, 4'h1};
    tbl[7] = '{32'h2AA8, 16, 2'd2, 10'h155, 4'h2};
    tbl[8] = '{32'h1004, 16, 2'd1, 10'h001, 4'h1};

    rst = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    cs = 1'b1;
    tick(3);
    chk_reset();
    rst = 1'b0;
    tick(8);

    for (int i = 0; i < 9; i++) begin
      te = '{int'(tbl[i].kind), tbl[i].code, tbl[i].ctl, 0};
      send(tbl[i].data, tbl[i].nbits, 4, 2, 2, te);
      m_code = tbl[i].code;
      m_ctrl = tbl[i].ctl;
    end
    drain();

    // sclk noise with cs high
    for (int i = 0; i < 20; i++) begin
      sclk = ~sclk;
      tick(2);
    end
    send(32'h1008, 16, 4, 2, 1, none);
    drain();

    // ramp 0..1023 then wrap to 0
    for (int c = 0; c <= 1024; c++) begin
      d = {16'h0, 4'h1, 10'(c), 2'b00};
      send(d, 16, 2, 2, 1, none);
    end
    drain();

    for (int i = 0; i < 40; i++) begin
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[15:12] = 4'h1;
      send(d, nb, int'($urandom_range(2, 3)), int'($urandom_range(2, 5)),
           1, none);
    end
    drain();

    // reset in the middle of a frame
    send(32'h1554, 16, 4, 2, 1, none);
    drain();
    d = 32'h1FFC;
    cs = 1'b0;
    tick(4);
    for (int i = 15; i >= 8; i--) begin
      mosi = d[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk_reset();
    m_code = '0;
    m_ctrl = '0;
    tick(2);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      mosi = d[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    cs = 1'b1;
    tick(8);
    send(32'h1004, 16, 4, 2, 1, none);
    drain();
    chk("final_code", 32'(dac_code), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
